lsu_ctrl: RTL

- Load/store controller sitting directly upstream of the 32-word data memory (word-only, synchronous read, write on posedge).
- Accepts one byte/halfword/word load or store from the execute stage.
- Runs a small FSM driving the memory's address, data, write-enable and read-enable, with read-modify-write for sub-word stores.
- Returns aligned, sign- or zero-extended load data and a one-cycle Done pulse; Busy stalls the core meanwhile.

---
 rtl/lsu_pkg.sv | 15 +
 rtl/lsu_align.sv | 52 +++++
 rtl/lsu_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller: op codes, FSM states, lane width.
package lsu_pkg;
  localparam int LANE_W = 8;

  typedef enum logic [2:0] {
    OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
    OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7
  } op_e;

  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, DONE} state_e;

  function automatic logic is_store(op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge, alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged,
  output logic        misaligned
);
  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  assign sh      = {lane, 3'b000};
  assign shifted = word >> sh;
  assign b       = shifted[LANE_W-1:0];
  assign h       = shifted[2*LANE_W-1:0];

  always_comb begin
    load_val = word;
    case (op)
      OP_LH:   load_val = {{16{h[15]}}, h};
      OP_LHU:  load_val = {16'h0, h};
      OP_LB:   load_val = {{24{b[7]}}, b};
      OP_LBU:  load_val = {24'h0, b};
      default: load_val = word;
    endcase
  end

  // Sub-word stores keep the untouched lanes of the word just read.
  always_comb begin
    merged = wdata;
    case (op)
      OP_SB:   merged = (word & ~(32'h0000_00FF << sh)) | ({24'h0, wdata[7:0]} << sh);
      OP_SH:   merged = (word & ~(32'h0000_FFFF << sh)) | ({16'h0, wdata[15:0]} << sh);
      default: merged = wdata;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (op)
      OP_LW, OP_SW:         misaligned = |lane;
      OP_LH, OP_LHU, OP_SH: misaligned = lane[0];
      default:              misaligned = 1'b0;
    endcase
  end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store FSM in front of a word-only synchronous data memory, with RMW for SB/SH.
// Define LSU_BOUNDS_CHECK_EN to flag addresses beyond the memory as errors instead of wrapping.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [2:0]    Op,
  input  logic [31:0]   Addr,
  input  logic [DW-1:0] Wdata,
  output logic [DW-1:0] Rdata,
  output logic          Done,
  output logic          Err,
  output logic          Busy,
  output logic [AW-1:0] dm_A,
  output logic [DW-1:0] dm_D,
  output logic          dm_Memwrite,
  output logic          dm_Memtoreg,
  input  logic [DW-1:0] dm_Q
);
  state_e      state, nxt;
  op_e         op_q, op_sel;
  logic [1:0]  lane_q, lane_sel;
  logic [31:0] wdata_q, load_val, merged;
  logic        err_q, misaligned, oob, accept;

  // Alignment is judged on the live request in IDLE, on the latched one afterwards.
  assign op_sel   = (state == IDLE) ? op_e'(Op) : op_q;
  assign lane_sel = (state == IDLE) ? Addr[1:0] : lane_q;
  assign accept   = (state == IDLE) && Start;

`ifdef LSU_BOUNDS_CHECK_EN
  assign oob = |Addr[31:AW+2];
`else
  assign oob = 1'b0;
`endif

  lsu_align u_align (
    .op         (op_sel),
    .lane       (lane_sel),
    .word       (dm_Q),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .merged     (merged),
    .misaligned (misaligned)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:
        if (Start) begin
          if (misaligned || oob)  nxt = DONE;
          else if (op_sel == OP_SW) nxt = WRITE;
          else                    nxt = READ;
        end
      READ:    nxt = CAPT;
      CAPT:    nxt = is_store(op_q) ? WRITE : DONE;
      WRITE:   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_q    <= OP_LW;
      lane_q  <= 2'b00;
      wdata_q <= '0;
      err_q   <= 1'b0;
      dm_A    <= '0;
      dm_D    <= '0;
      Rdata   <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_e'(Op);
        lane_q  <= Addr[1:0];
        wdata_q <= Wdata;
        err_q   <= misaligned || oob;
        dm_A    <= Addr[AW+1:2];
        dm_D    <= Wdata;
      end
      if (state == CAPT) begin
        if (is_store(op_q)) dm_D  <= merged;
        else                Rdata <= load_val;
      end
    end
  end

  // Strobes decode straight from state so a reset removes them without waiting for a clock.
  assign Busy        = (state != IDLE);
  assign Done        = (state == DONE);
  assign Err         = Done && err_q;
  assign dm_Memwrite = (state == WRITE);
  assign dm_Memtoreg = (state == READ);
endmodule
